// File: rtl/cond_branch_unit.sv
// Branch-resolution unit: CC-set storage with write bypass, SPARC condition evaluation, registered result.
// Define CBU_STATS_EN to add the saturating taken/not-taken counters and their ports.
module cond_branch_unit #(
  parameter int unsigned NUM_CC  = 2,
  parameter int unsigned CCSEL_W = 1,
  parameter int unsigned TAG_W   = 8,
  parameter int unsigned STAT_W  = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cc_we,
  input  logic [CCSEL_W-1:0] cc_wsel,
  input  logic [3:0]         cc_wdata,
  input  logic               br_valid,
  output logic               br_ready,
  input  logic [3:0]         br_cond,
  input  logic               br_annul,
  input  logic [CCSEL_W-1:0] br_ccsel,
  input  logic [TAG_W-1:0]   br_tag,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               res_taken,
  output logic               res_annul_slot,
  output logic               res_err,
  output logic [TAG_W-1:0]   res_tag,
  input  logic [CCSEL_W-1:0] cc_rd_sel,
  output logic [3:0]         cc_rdata
`ifdef CBU_STATS_EN
  ,
  output logic [STAT_W-1:0]  stat_taken,
  output logic [STAT_W-1:0]  stat_not_taken
`endif
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [3:0]       cc_q [NUM_CC];
  logic [3:0]       cc_d [NUM_CC];
  logic [0:0]       state_q, state_d;
  logic             res_taken_q, res_taken_d;
  logic             res_annul_q, res_annul_d;
  logic             res_err_q, res_err_d;
  logic [TAG_W-1:0] res_tag_q, res_tag_d;

  logic       accept;
  logic       ccsel_ok;
  logic [3:0] sel_cc;
  logic       cond_true;
  logic       eval_taken;
  logic       n_f, z_f, v_f, c_f;

  assign res_valid      = (state_q == ST_FULL);
  assign br_ready       = !res_valid | res_ready;
  assign accept         = br_valid & br_ready;
  assign res_taken      = res_taken_q;
  assign res_annul_slot = res_annul_q;
  assign res_err        = res_err_q;
  assign res_tag        = res_tag_q;

  // Loops rather than direct indexing keep CCSEL_W independent of the array depth.
  always_comb begin
    sel_cc   = '0;
    cc_rdata = '0;
    for (int unsigned i = 0; i < NUM_CC; i++) begin
      if (32'(br_ccsel) == i)  sel_cc   = cc_q[i];
      if (32'(cc_rd_sel) == i) cc_rdata = cc_q[i];
    end
    if (cc_we && (cc_wsel == br_ccsel)) sel_cc = cc_wdata;
  end

  always_comb begin
    {n_f, z_f, v_f, c_f} = sel_cc;
    cond_true = 1'b0;
    case (br_cond)
      4'h0: cond_true = 1'b1;
      4'h1: cond_true = !z_f;
      4'h2: cond_true = z_f;
      4'h3: cond_true = !(z_f | (n_f ^ v_f));
      4'h4: cond_true = z_f | (n_f ^ v_f);
      4'h5: cond_true = !(n_f ^ v_f);
      4'h6: cond_true = n_f ^ v_f;
      4'h7: cond_true = !(c_f | z_f);
      4'h8: cond_true = c_f | z_f;
      4'h9: cond_true = !c_f;
      4'hA: cond_true = c_f;
      4'hB: cond_true = !n_f;
      4'hC: cond_true = n_f;
      4'hD: cond_true = !v_f;
      4'hE: cond_true = v_f;
      default: cond_true = 1'b0;
    endcase
    ccsel_ok   = (32'(br_ccsel) < NUM_CC);
    eval_taken = ccsel_ok ? cond_true : (br_cond == 4'h0);
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_CC; i++) begin
      cc_d[i] = cc_q[i];
      if (cc_we && (32'(cc_wsel) == i)) cc_d[i] = cc_wdata;
    end
    state_d     = state_q;
    res_taken_d = res_taken_q;
    res_annul_d = res_annul_q;
    res_err_d   = res_err_q;
    res_tag_d   = res_tag_q;
    if (accept) begin
      state_d     = ST_FULL;
      res_taken_d = eval_taken;
      res_annul_d = br_annul & (!eval_taken | (br_cond == 4'h0));
      res_err_d   = !ccsel_ok;
      res_tag_d   = br_tag;
    end else if (res_ready) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_CC; i++) cc_q[i] <= '0;
      state_q     <= ST_EMPTY;
      res_taken_q <= 1'b0;
      res_annul_q <= 1'b0;
      res_err_q   <= 1'b0;
      res_tag_q   <= '0;
    end else begin
      cc_q        <= cc_d;
      state_q     <= state_d;
      res_taken_q <= res_taken_d;
      res_annul_q <= res_annul_d;
      res_err_q   <= res_err_d;
      res_tag_q   <= res_tag_d;
    end
  end

`ifdef CBU_STATS_EN
  logic [STAT_W-1:0] stat_taken_q, stat_taken_d;
  logic [STAT_W-1:0] stat_not_taken_q, stat_not_taken_d;

  always_comb begin
    stat_taken_d     = stat_taken_q;
    stat_not_taken_d = stat_not_taken_q;
    if (accept) begin
      if (eval_taken && (stat_taken_q != '1))
        stat_taken_d = stat_taken_q + STAT_W'(1);
      if (!eval_taken && (stat_not_taken_q != '1))
        stat_not_taken_d = stat_not_taken_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stat_taken_q     <= '0;
      stat_not_taken_q <= '0;
    end else begin
      stat_taken_q     <= stat_taken_d;
      stat_not_taken_q <= stat_not_taken_d;
    end
  end

  assign stat_taken     = stat_taken_q;
  assign stat_not_taken = stat_not_taken_q;
`endif

endmodule

// File: tb/tb_cond_branch_unit.sv
// Self-checking bench for cond_branch_unit: directed scenarios plus randomized traffic against a reference model.
module tb_cond_branch_unit;
  localparam int unsigned NUM_CC  = 2;
  localparam int unsigned CCSEL_W = 2;
  localparam int unsigned TAG_W   = 8;
  localparam int unsigned STAT_W  = 16;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               cc_we;
  logic [CCSEL_W-1:0] cc_wsel;
  logic [3:0]         cc_wdata;
  logic               br_valid;
  logic               br_ready;
  logic [3:0]         br_cond;
  logic               br_annul;
  logic [CCSEL_W-1:0] br_ccsel;
  logic [TAG_W-1:0]   br_tag;
  logic               res_valid;
  logic               res_ready;
  logic               res_taken;
  logic               res_annul_slot;
  logic               res_err;
  logic [TAG_W-1:0]   res_tag;
  logic [CCSEL_W-1:0] cc_rd_sel;
  logic [3:0]         cc_rdata;
`ifdef CBU_STATS_EN
  logic [STAT_W-1:0]  stat_taken;
  logic [STAT_W-1:0]  stat_not_taken;
`endif

  cond_branch_unit #(.NUM_CC(NUM_CC), .CCSEL_W(CCSEL_W), .TAG_W(TAG_W), .STAT_W(STAT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .cc_we(cc_we), .cc_wsel(cc_wsel), .cc_wdata(cc_wdata),
    .br_valid(br_valid), .br_ready(br_ready), .br_cond(br_cond), .br_annul(br_annul),
    .br_ccsel(br_ccsel), .br_tag(br_tag),
    .res_valid(res_valid), .res_ready(res_ready), .res_taken(res_taken),
    .res_annul_slot(res_annul_slot), .res_err(res_err), .res_tag(res_tag),
    .cc_rd_sel(cc_rd_sel), .cc_rdata(cc_rdata)
`ifdef CBU_STATS_EN
    , .stat_taken(stat_taken), .stat_not_taken(stat_not_taken)
`endif
  );

  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;

  // Reference model state
  bit       m_valid, m_taken, m_annul, m_err;
  bit [7:0] m_tag;
  bit [3:0] m_cc [4];
  int       m_st_t, m_st_nt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Conditions described by their meaning: signed less-than is N!=V, unsigned lower-or-same is C|Z.
  function automatic bit ref_cond(input bit [3:0] cond, input bit [3:0] f);
    bit n = f[3], z = f[2], v = f[1], c = f[0];
    bit slt = (n != v);
    bit ule = c || z;
    case (cond)
      0:  return 1;
      1:  return !z;
      2:  return z;
      3:  return !slt && !z;
      4:  return slt || z;
      5:  return !slt;
      6:  return slt;
      7:  return !ule;
      8:  return ule;
      9:  return !c;
      10: return c;
      11: return !n;
      12: return n;
      13: return !v;
      14: return v;
      default: return 0;
    endcase
  endfunction

  task automatic model_edge();
    bit       ready, tk, in_range;
    bit [3:0] f;
    int       sel;
    if (!reset_n) begin
      m_valid = 0; m_taken = 0; m_annul = 0; m_err = 0; m_tag = 0;
      foreach (m_cc[i]) m_cc[i] = 0;
      m_st_t = 0; m_st_nt = 0;
      return;
    end
    ready = !m_valid || res_ready;
    if (br_valid && ready) begin
      sel      = int'(br_ccsel);
      in_range = sel < int'(NUM_CC);
      f        = (cc_we && cc_wsel == br_ccsel) ? cc_wdata : m_cc[sel];
      tk       = in_range ? ref_cond(br_cond, f) : (br_cond == 0);
      m_valid  = 1;
      m_taken  = tk;
      m_err    = !in_range;
      m_annul  = br_annul && (!tk || br_cond == 0);
      m_tag    = br_tag;
      if (tk) m_st_t  = (m_st_t  < 65535) ? m_st_t + 1  : m_st_t;
      else    m_st_nt = (m_st_nt < 65535) ? m_st_nt + 1 : m_st_nt;
    end else if (res_ready) begin
      m_valid = 0;
    end
    if (cc_we && int'(cc_wsel) < int'(NUM_CC)) m_cc[cc_wsel] = cc_wdata;
  endtask

  task automatic cycle();
    bit [3:0] exp_rd;
    #1;
    check_eq("br_ready", br_ready, !m_valid || res_ready);
    @(posedge clk);
    model_edge();
    #1;
    check_eq("res_valid", res_valid, m_valid);
    check_eq("res_taken", res_taken, m_taken);
    check_eq("res_annul_slot", res_annul_slot, m_annul);
    check_eq("res_err", res_err, m_err);
    check_eq("res_tag", res_tag, m_tag);
    exp_rd = (int'(cc_rd_sel) < int'(NUM_CC)) ? m_cc[cc_rd_sel] : 4'h0;
    check_eq("cc_rdata", cc_rdata, exp_rd);
`ifdef CBU_STATS_EN
    check_eq("stat_taken", stat_taken, m_st_t);
    check_eq("stat_not_taken", stat_not_taken, m_st_nt);
`endif
  endtask

  task automatic idle();
    cc_we = 0; br_valid = 0; res_ready = 1; br_annul = 0;
  endtask

  task automatic req(input bit [3:0] cond, input bit a, input bit [1:0] sel, input bit [7:0] tag);
    br_valid = 1; br_cond = cond; br_annul = a; br_ccsel = sel; br_tag = tag;
  endtask

  initial begin
    reset_n = 0; cc_we = 1; cc_wsel = 0; cc_wdata = 4'hF;
    br_valid = 1; br_cond = 0; br_annul = 1; br_ccsel = 0; br_tag = 8'hAA;
    res_ready = 0; cc_rd_sel = 0;
    @(posedge clk);
    model_edge();
    #1;
    // Requests and CC writes during reset are ignored
    cycle();
    check_eq("reset_valid", res_valid, 0);
    check_eq("reset_cc0", cc_rdata, 0);
    reset_n = 1; idle(); cycle();

    cc_we = 1; cc_wsel = 0; cc_wdata = 4'b0100; cycle();
    cc_we = 0; req(4'h2, 0, 0, 8'h11); cycle();
    check_eq("be_valid", res_valid, 1);
    check_eq("be_taken", res_taken, 1);
    check_eq("be_annul", res_annul_slot, 0);
    check_eq("be_tag", res_tag, 8'h11);

    cc_we = 1; cc_wsel = 1; cc_wdata = 4'b0001; req(4'h7, 1, 1, 8'h22); cycle();
    check_eq("bgu_bypass_taken", res_taken, 0);
    check_eq("bgu_bypass_annul", res_annul_slot, 1);
    cc_we = 0; req(4'hA, 0, 1, 8'h23); cycle();
    check_eq("bcs_store_taken", res_taken, 1);

    req(4'h0, 1, 1, 8'h24); cycle();
    check_eq("ba_a_taken", res_taken, 1);
    check_eq("ba_a_annul", res_annul_slot, 1);
    req(4'hF, 1, 1, 8'h25); cycle();
    check_eq("bn_a_taken", res_taken, 0);
    check_eq("bn_a_annul", res_annul_slot, 1);
    req(4'h1, 1, 1, 8'h26); cycle();
    check_eq("bne_a_taken", res_taken, 1);
    check_eq("bne_a_annul", res_annul_slot, 0);

    res_ready = 0; req(4'h0, 0, 0, 8'h30);
    for (int i = 0; i < 2; i++) begin
      cycle();
      check_eq("stall_ready", br_ready, 0);
      check_eq("stall_tag", res_tag, 8'h26);
    end
    res_ready = 1;
    for (int i = 0; i < 3; i++) begin
      br_tag = 8'(8'h30 + i); cycle();
      check_eq("b2b_tag", res_tag, 8'(8'h30 + i));
    end

    req(4'h2, 0, 3, 8'h40); cycle();
    check_eq("oor_be_err", res_err, 1);
    check_eq("oor_be_taken", res_taken, 0);
    req(4'h0, 0, 3, 8'h41); cycle();
    check_eq("oor_ba_err", res_err, 1);
    check_eq("oor_ba_taken", res_taken, 1);

    reset_n = 0; idle(); cycle(); reset_n = 1; cycle();
    for (int i = 0; i < 8; i++) begin
      req(i < 5 ? 4'h0 : 4'hF, 0, 0, 8'(i)); cycle();
    end
`ifdef CBU_STATS_EN
    check_eq("stats_taken5", stat_taken, 5);
    check_eq("stats_untaken3", stat_not_taken, 3);
`endif
    reset_n = 0; idle(); cycle();
    check_eq("rst_full_valid", res_valid, 0);
    check_eq("rst_full_cc", cc_rdata, 0);
`ifdef CBU_STATS_EN
    check_eq("stats_clr_t", stat_taken, 0);
    check_eq("stats_clr_nt", stat_not_taken, 0);
`endif
    reset_n = 1;

    for (int i = 0; i < 400; i++) begin
      reset_n   = ($urandom_range(0, 49) != 0);
      cc_we     = $urandom_range(0, 1);
      cc_wsel   = 2'($urandom_range(0, 3));
      cc_wdata  = 4'($urandom);
      br_valid  = ($urandom_range(0, 3) != 0);
      br_cond   = 4'($urandom);
      br_annul  = $urandom_range(0, 1);
      br_ccsel  = 2'($urandom_range(0, 3));
      br_tag    = 8'($urandom);
      res_ready = ($urandom_range(0, 3) != 0);
      cc_rd_sel = 2'($urandom_range(0, 3));
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/cond_branch_unit.md
# cond_branch_unit

Parametrised branch-resolution unit for the pipeline, successor to the combinational condition handler. It holds `NUM_CC` condition-code registers written by the ALU/FPU side and accepts branch requests through a valid/ready handshake. For each request it evaluates the SPARC condition against the selected (bypassed) code set and returns a registered result: taken, delay-slot annul, and a pass-through tag. It sits between decode/ID and the PC-select/flush logic.

## Interface
- `NUM_CC`, 2, number of condition-code sets (icc, xcc, ...); 1..8
- `CCSEL_W`, 1, width of CC-set select; must satisfy 2^CCSEL_W >= NUM_CC
- `TAG_W`, 8, width of opaque request tag (PC index / ROB id)
- `STAT_W`, 16, width of statistics counters (used only with `CBU_STATS_EN`)

- `clk` in 1 — single clock; all state changes on rising edge
- `reset_n` in 1 — synchronous, active-low reset
- `cc_we` in 1 — write enable for one CC set
- `cc_wsel` in CCSEL_W — CC set written
- `cc_wdata` in 4 — {N,Z,V,C}
- `br_valid` in 1 — branch request valid
- `br_ready` out 1 — unit can accept a request this cycle
- `br_cond` in 4 — condition field
- `br_annul` in 1 — instruction `a` bit
- `br_ccsel` in CCSEL_W — CC set evaluated
- `br_tag` in TAG_W — carried to result unchanged
- `res_valid` out 1 — result valid
- `res_ready` in 1 — consumer accepts result
- `res_taken` out 1 — branch taken
- `res_annul_slot` out 1 — delay-slot instruction must be squashed
- `res_err` out 1 — `br_ccsel` >= NUM_CC
- `res_tag` out TAG_W — echoed tag
- `cc_rd_sel` in CCSEL_W / `cc_rdata` out 4 — combinational debug/readout of stored CC set (0 if out of range)
- `stat_taken`, `stat_not_taken` out STAT_W — present only with `CBU_STATS_EN`

## Operation
- CC write: when `cc_we` and `cc_wsel` < NUM_CC, `cc[cc_wsel] <= cc_wdata` at the edge; out-of-range writes ignored.
- Accept: request accepted on an edge where `br_valid && br_ready`.
- Bypass: if `cc_we` and `cc_wsel == br_ccsel` in the accept cycle, evaluation uses `cc_wdata`, not the stored value; the store still updates.
- Condition (N,Z,V,C from the chosen set): 0000 BA=1; 0001 BNE=!Z; 0010 BE=Z; 0011 BG=!(Z|(N^V)); 0100 BLE=Z|(N^V); 0101 BGE=!(N^V); 0110 BL=N^V; 0111 BGU=!(C|Z); 1000 BLEU=C|Z; 1001 BCC=!C; 1010 BCS=C; 1011 BPOS=!N; 1100 BNEG=N; 1101 BVC=!V; 1110 BVS=V; 1111 BN=0.
- Annul: `res_annul_slot = br_annul & (!taken | cond==0000)` (BA,a annuls slot; BN,a annuls slot; conditional taken never annuls).
- Out-of-range `br_ccsel`: `res_err=1`, `res_taken=0`, annul per rule with taken=0, except BA gives taken=1 (no CC dependence).
- Result register: two states, EMPTY (`res_valid=0`) and FULL (`res_valid=1`). EMPTY→FULL on accept; FULL→EMPTY on `res_ready` with no new accept; FULL→FULL on `res_ready` plus accept, replacing contents. Contents stable while FULL and `res_ready=0`.
- `br_ready = !res_valid | res_ready`; combinational from `res_ready`.

## Timing
- Latency: result visible the cycle after accept; throughput one branch per cycle when `res_ready` is held high.
- CC write at edge N is visible to a branch accepted in cycle N via bypass and to all later branches via store.
- Reset (`reset_n=0` at an edge): all `cc` sets=0000, `res_valid=0`, `res_taken=0`, `res_annul_slot=0`, `res_err=0`, `res_tag=0`, counters=0; a pending result is dropped. During reset `br_ready` follows the formula (1 after first reset edge); requests and CC writes in reset cycles are ignored.

## Configuration
- `CBU_STATS_EN` defined: `stat_taken` / `stat_not_taken` increment by 1 on each accepted request with taken=1 / taken=0 (err requests counted as not-taken unless BA), saturating at 2^STAT_W−1, cleared by reset.
- Undefined: counters and their ports absent; all other behaviour identical.

## Test plan
- Reset, then write cc[0]=0100 (Z=1), request BE ccsel=0 tag=0x11 → next cycle `res_valid=1`, taken=1, annul=0, tag=0x11.
- Same cycle: `cc_we`, wsel=1, wdata=0001 (C=1) and request BGU ccsel=1 a=1 → taken=0, annul_slot=1; following BCS on set 1 → taken=1.
- BA a=1 → taken=1, annul_slot=1; BN a=1 → taken=0, annul_slot=1; BNE a=1 with Z=0 → taken=1, annul_slot=0.
- Hold `res_ready=0` two cycles with `br_valid=1` → `br_ready=0`, result stable; raise `res_ready` → back-to-back results, one per cycle, tags in order.
- `br_ccsel=3` with NUM_CC=2, cond BE → `res_err=1`, taken=0; cond BA → `res_err=1`, taken=1.
- Assert `reset_n=0` while FULL → `res_valid=0`, `cc_rdata=0000`; with `CBU_STATS_EN`, 5 taken + 3 untaken → counters 5/3, then 0/0 after reset.
